way_select_encoder: RTL and testbench
=====================================

WAY_SELECT_ENCODER -- requirements
Module: way_select_encoder

Interface
REQ-001 Parameter WAYS, default 8, number of cache ways; power of two, 2..64.
REQ-002 Derived constant AW = clog2(WAYS), default 3, index width; not overridable.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block accepts the request this cycle.
REQ-007 req_mode  input  1  0 = DECODE (one-hot of req_addr), 1 = ALLOC (victim selection).
REQ-008 req_addr  input  AW  way index for DECODE; ignored in ALLOC.
REQ-009 way_valid  input  WAYS  per-way valid bits for the addressed set; sampled with the request.
REQ-010 sel_valid  output  1  selection result present.
REQ-011 sel_ready  input  1  consumer accepts the result.
REQ-012 selector  output  WAYS  one-hot selected way.
REQ-013 sel_index  output  AW  binary index of the selected way.
REQ-014 sel_alloc  output  1  result came from an ALLOC request.

Function
REQ-015 Request is accepted when req_valid and req_ready are both 1 on a rising edge.
REQ-016 req_ready = !sel_valid || sel_ready; a result is consumed in the same cycle as a new request is accepted.
REQ-017 Latency: result appears on selector/sel_index one cycle after acceptance, with sel_valid = 1.
REQ-018 While sel_valid = 1 and sel_ready = 0, selector, sel_index and sel_alloc hold stable.
REQ-019 If sel_ready = 1 and no request is accepted, sel_valid drops to 0 on the next edge; selector and sel_index keep their last values.
REQ-020 DECODE: selector = 1 << req_addr, sel_index = req_addr; the round-robin pointer is unchanged.
REQ-021 ALLOC with any way_valid bit 0: select the lowest-index invalid way; the pointer is unchanged.
REQ-022 ALLOC with way_valid all ones: select the way at the round-robin pointer rr_ptr; rr_ptr advances by 1 modulo WAYS.
REQ-023 rr_ptr wrap: rr_ptr = WAYS-1 advances to 0.
REQ-024 Requests not accepted (req_ready = 0) have no effect on rr_ptr or outputs.
REQ-025 selector is always exactly one-hot when sel_valid = 1.

Reset
REQ-026 Asserting rst_n low clears the block immediately, independent of clk: sel_valid = 0, selector = 0, sel_index = 0, sel_alloc = 0, rr_ptr = 0.
REQ-027 req_ready = 1 during and after reset; no request is accepted while rst_n = 0.
REQ-028 Reset mid-transaction discards the pending result; the first accepted request after release uses rr_ptr = 0.

Structure
REQ-029 Shared package way_sel_pkg holds the mode constants MODE_DECODE = 0 and MODE_ALLOC = 1.
REQ-030 A single sub-module, first_zero_finder (WAYS-wide lowest-index zero detector with found flag and binary index), is instantiated once.
REQ-031 The output stage is one register with no FIFO; rr_ptr is the only other state.

Verification
REQ-032 DECODE sweep, WAYS=8, sel_ready=1: req_addr 0..7 back-to-back -> selector 0x01..0x80 one cycle later, sel_index = addr, rr_ptr stays 0.
REQ-033 ALLOC, way_valid = 0xF3 -> selector 0x04, sel_index 2, rr_ptr unchanged.
REQ-034 ALLOC x9, way_valid = 0xFF -> sel_index 0,1,...,7,0; rr_ptr = 1 at the end.
REQ-035 Back-pressure: sel_ready = 0 for 3 cycles after a result -> req_ready = 0, outputs stable; on sel_ready = 1, a new result is accepted in the same cycle.
REQ-036 Reset mid-stream: rst_n low asynchronously with sel_valid = 1 and rr_ptr = 5 -> outputs 0 at once; first ALLOC (all valid) after release -> sel_index 0.
REQ-037 WAYS=4 build: ALLOC x5 with way_valid = 0xF -> sel_index 0,1,2,3,0; DECODE addr 3 -> selector 0x8.

Source files
------------

// File: rtl/way_select_encoder_pkg.sv
// Shared constants for the way select encoder: request mode encodings.
package way_sel_pkg;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_ALLOC  = 1'b1;

endpackage

// File: rtl/way_select_encoder_if.sv
// Request/result bundle between a cache controller (master) and the way select encoder (slave).
interface way_select_encoder_if #(
  parameter int WAYS = 8
);
  localparam int AW = $clog2(WAYS);

  logic            req_valid;
  logic            req_ready;
  logic            req_mode;
  logic [AW-1:0]   req_addr;
  logic [WAYS-1:0] way_valid;
  logic            sel_valid;
  logic            sel_ready;
  logic [WAYS-1:0] selector;
  logic [AW-1:0]   sel_index;
  logic            sel_alloc;

  modport master (
    output req_valid, req_mode, req_addr, way_valid, sel_ready,
    input  req_ready, sel_valid, selector, sel_index, sel_alloc
  );

  modport slave (
    input  req_valid, req_mode, req_addr, way_valid, sel_ready,
    output req_ready, sel_valid, selector, sel_index, sel_alloc
  );
endinterface

// File: rtl/way_select_encoder_first_zero_finder.sv
// Lowest-index zero detector: reports whether any bit of vec_i is 0 and the index of the lowest one.
module first_zero_finder #(
  parameter int WIDTH = 8,
  localparam int IW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             found_o,
  output logic [IW-1:0]    idx_o
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!vec_i[i]) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/way_select_encoder.sv
// Way select encoder: one-hot decode of a way index, or victim selection (first invalid way, else round-robin).
module way_select_encoder
  import way_sel_pkg::*;
#(
  parameter int WAYS = 8,
  localparam int AW  = $clog2(WAYS)
) (
  input logic                clk,
  input logic                rst_n,
  way_select_encoder_if.slave bus
);

  logic            sel_valid_q, sel_valid_d;
  logic [WAYS-1:0] selector_q,  selector_d;
  logic [AW-1:0]   sel_index_q, sel_index_d;
  logic            sel_alloc_q, sel_alloc_d;
  logic [AW-1:0]   rr_ptr_q,    rr_ptr_d;

  logic            accept;
  logic            ffz_found;
  logic [AW-1:0]   ffz_idx;

  first_zero_finder #(.WIDTH(WAYS)) u_ffz (
    .vec_i   (bus.way_valid),
    .found_o (ffz_found),
    .idx_o   (ffz_idx)
  );

  assign bus.req_ready = !sel_valid_q || bus.sel_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  // The pointer only moves when every way is valid; AW-bit wrap gives modulo WAYS.
  always_comb begin
    sel_valid_d = sel_valid_q;
    selector_d  = selector_q;
    sel_index_d = sel_index_q;
    sel_alloc_d = sel_alloc_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      sel_valid_d = 1'b1;
      sel_alloc_d = bus.req_mode;
      if (bus.req_mode == MODE_DECODE) begin
        sel_index_d = bus.req_addr;
      end else if (ffz_found) begin
        sel_index_d = ffz_idx;
      end else begin
        sel_index_d = rr_ptr_q;
        rr_ptr_d    = rr_ptr_q + AW'(1);
      end
      selector_d = {{(WAYS-1){1'b0}}, 1'b1} << sel_index_d;
    end else if (bus.sel_ready) begin
      sel_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_valid_q <= 1'b0;
      selector_q  <= '0;
      sel_index_q <= '0;
      sel_alloc_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      sel_valid_q <= sel_valid_d;
      selector_q  <= selector_d;
      sel_index_q <= sel_index_d;
      sel_alloc_q <= sel_alloc_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.sel_valid = sel_valid_q;
  assign bus.selector  = selector_q;
  assign bus.sel_index = sel_index_q;
  assign bus.sel_alloc = sel_alloc_q;

endmodule

// File: tb/tb_way_select_encoder.sv
// Directed bench for way_select_encoder: an 8-way and a 4-way instance sharing one clock and reset.
module tb_way_select_encoder;

  logic clk;
  logic rst_n;

  int vecCount  = 0;
  int missCount = 0;

  way_select_encoder_if #(.WAYS(8)) bus8 ();
  way_select_encoder_if #(.WAYS(4)) bus4 ();

  way_select_encoder #(.WAYS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  way_select_encoder #(.WAYS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] decTab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [7:0] selTab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  int         rr8Tab [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
  int         rr4Tab [5] = '{0, 1, 2, 3, 0};
  logic [3:0] sel4Tab[5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request on the 8-way bus and advance to just after the next rising edge.
  task automatic applyStimulus(input logic v, input logic m, input logic [2:0] a,
                               input logic [7:0] wv, input logic rdy);
    bus8.req_valid = v;
    bus8.req_mode  = m;
    bus8.req_addr  = a;
    bus8.way_valid = wv;
    bus8.sel_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus4(input logic v, input logic m, input logic [1:0] a,
                                input logic [3:0] wv, input logic rdy);
    bus4.req_valid = v;
    bus4.req_mode  = m;
    bus4.req_addr  = a;
    bus4.way_valid = wv;
    bus4.sel_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus8.req_valid = 1'b0; bus8.req_mode = 1'b0; bus8.req_addr = '0;
    bus8.way_valid = '0;   bus8.sel_ready = 1'b1;
    bus4.req_valid = 1'b0; bus4.req_mode = 1'b0; bus4.req_addr = '0;
    bus4.way_valid = '0;   bus4.sel_ready = 1'b1;

    #3;
    checkOutput("rst_sel_valid", 64'(bus8.sel_valid), 64'd0);
    checkOutput("rst_selector",  64'(bus8.selector),  64'd0);
    checkOutput("rst_sel_index", 64'(bus8.sel_index), 64'd0);
    checkOutput("rst_sel_alloc", 64'(bus8.sel_alloc), 64'd0);
    checkOutput("rst_req_ready", 64'(bus8.req_ready), 64'd1);
    checkOutput("rst_rr_ptr",    64'(dut8.rr_ptr_q),  64'd0);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decode sweep, back-to-back with the consumer always ready.
    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b1, 1'b0, 3'(a), 8'h00, 1'b1);
      checkOutput($sformatf("dec_valid_%0d", a), 64'(bus8.sel_valid), 64'd1);
      checkOutput($sformatf("dec_sel_%0d", a),   64'(bus8.selector),  64'(decTab[a]));
      checkOutput($sformatf("dec_idx_%0d", a),   64'(bus8.sel_index), 64'(a));
      checkOutput($sformatf("dec_alloc_%0d", a), 64'(bus8.sel_alloc), 64'd0);
    end
    checkOutput("dec_rr_ptr", 64'(dut8.rr_ptr_q), 64'd0);

    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
    checkOutput("idle_valid", 64'(bus8.sel_valid), 64'd0);
    checkOutput("idle_sel",   64'(bus8.selector),  64'h80);
    checkOutput("idle_idx",   64'(bus8.sel_index), 64'd7);

    applyStimulus(1'b1, 1'b1, 3'd6, 8'hF3, 1'b1);
    checkOutput("allocF3_sel",   64'(bus8.selector),  64'h04);
    checkOutput("allocF3_idx",   64'(bus8.sel_index), 64'd2);
    checkOutput("allocF3_alloc", 64'(bus8.sel_alloc), 64'd1);
    checkOutput("allocF3_rr",    64'(dut8.rr_ptr_q),  64'd0);

    applyStimulus(1'b1, 1'b1, 3'd0, 8'h7F, 1'b1);
    checkOutput("alloc7F_idx", 64'(bus8.sel_index), 64'd7);
    checkOutput("alloc7F_sel", 64'(bus8.selector),  64'h80);
    applyStimulus(1'b1, 1'b1, 3'd5, 8'hFE, 1'b1);
    checkOutput("allocFE_idx", 64'(bus8.sel_index), 64'd0);
    checkOutput("allocFE_rr",  64'(dut8.rr_ptr_q),  64'd0);

    // All ways valid: round-robin victims, wrapping from 7 back to 0.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
      checkOutput($sformatf("rr8_idx_%0d", k), 64'(bus8.sel_index), 64'(rr8Tab[k]));
      checkOutput($sformatf("rr8_sel_%0d", k), 64'(bus8.selector),  64'(selTab[rr8Tab[k]]));
    end
    checkOutput("rr8_final_ptr", 64'(dut8.rr_ptr_q), 64'd1);

    applyStimulus(1'b1, 1'b0, 3'd5, 8'h00, 1'b1);
    checkOutput("bp_first_sel", 64'(bus8.selector), 64'h20);
    bus8.req_valid = 1'b1; bus8.req_mode = 1'b0; bus8.req_addr = 3'd6; bus8.sel_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("bp_ready_%0d", c), 64'(bus8.req_ready), 64'd0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_valid_%0d", c), 64'(bus8.sel_valid), 64'd1);
      checkOutput($sformatf("bp_sel_%0d", c),   64'(bus8.selector),  64'h20);
      checkOutput($sformatf("bp_idx_%0d", c),   64'(bus8.sel_index), 64'd5);
    end
    bus8.sel_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 64'(bus8.req_ready), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("bp_new_sel", 64'(bus8.selector),  64'h40);
    checkOutput("bp_new_idx", 64'(bus8.sel_index), 64'd6);

    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
    checkOutput("pre_rst_rr",    64'(dut8.rr_ptr_q),  64'd5);
    checkOutput("pre_rst_valid", 64'(bus8.sel_valid), 64'd1);

    // Asynchronous reset between clock edges with a result still pending.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(bus8.sel_valid), 64'd0);
    checkOutput("arst_sel",   64'(bus8.selector),  64'd0);
    checkOutput("arst_idx",   64'(bus8.sel_index), 64'd0);
    checkOutput("arst_alloc", 64'(bus8.sel_alloc), 64'd0);
    checkOutput("arst_rr",    64'(dut8.rr_ptr_q),  64'd0);
    checkOutput("arst_ready", 64'(bus8.req_ready), 64'd1);
    applyStimulus(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
    checkOutput("arst_no_accept", 64'(bus8.sel_valid), 64'd0);
    #3;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
    checkOutput("post_rst_idx", 64'(bus8.sel_index), 64'd0);
    checkOutput("post_rst_sel", 64'(bus8.selector),  64'h01);
    checkOutput("post_rst_rr",  64'(dut8.rr_ptr_q),  64'd1);
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);

    for (int k = 0; k < 5; k++) begin
      applyStimulus4(1'b1, 1'b1, 2'd0, 4'hF, 1'b1);
      checkOutput($sformatf("rr4_idx_%0d", k), 64'(bus4.sel_index), 64'(rr4Tab[k]));
      checkOutput($sformatf("rr4_sel_%0d", k), 64'(bus4.selector),  64'(sel4Tab[k]));
    end
    applyStimulus4(1'b1, 1'b0, 2'd3, 4'h0, 1'b1);
    checkOutput("w4_dec_sel",   64'(bus4.selector),  64'h8);
    checkOutput("w4_dec_idx",   64'(bus4.sel_index), 64'd3);
    checkOutput("w4_dec_alloc", 64'(bus4.sel_alloc), 64'd0);
    applyStimulus4(1'b0, 1'b0, 2'd0, 4'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
